// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end.
// Owns the fetch PC, issues pipelined requests to a variable-latency instruction
// memory and buffers returned words with their PCs in a prefetch FIFO that decode
// pops over valid/ready. A redirect flushes the FIFO and drops every response
// still in flight.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN. When defined, a misaligned
// redirect target produces a single NOP marker entry flagged out_misaligned and
// halts fetching until the next redirect or reset. When undefined, the low two
// bits of the redirect target are cleared and out_misaligned is tied low.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            out_misaligned
);

  localparam int PW = $clog2(DEPTH);
  // One spare bit so count + outstanding (at most 2*DEPTH) never wraps.
  localparam int CW = $clog2(DEPTH + 1) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] fifo_pc    [DEPTH];
  logic [31:0]     fifo_instr [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;

  logic            req_fire;
  logic            rsp_fire;
  logic            rsp_drop;
  logic            push;
  logic            pop;
  logic            credit_ok;
  logic            fetch_en;
  logic [XLEN-1:0] redir_target;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic halted;
  logic redir_mis;
  logic fifo_mis [DEPTH];

  assign redir_target   = redirect_pc;
  assign redir_mis      = (redirect_pc[1:0] != 2'b00);
  assign fetch_en       = !halted;
  assign out_misaligned = out_valid && fifo_mis[rd_ptr];
`else
  assign redir_target   = redirect_pc & ~XLEN'(3);
  assign fetch_en       = 1'b1;
  assign out_misaligned = 1'b0;
`endif

  // Every in-flight request already owns a FIFO slot, so a response push can
  // never overflow. The credit check uses registered state only, which keeps
  // imem_rsp_* out of the combinational path to imem_req_*.
  assign credit_ok      = (outstanding < CW'(MAX_OUT)) &&
                          ((count + outstanding) < CW'(DEPTH));
  assign imem_req_valid = !rst && !redirect_valid && fetch_en && credit_ok;
  assign imem_req_addr  = fetch_pc;

  assign req_fire  = imem_req_valid && imem_req_ready;
  assign rsp_fire  = imem_rsp_valid;
  assign rsp_drop  = rsp_fire && (drop_cnt != '0);
  assign push      = rsp_fire && !rsp_drop && !redirect_valid;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready && !redirect_valid;

  assign out_pc    = fifo_pc[rd_ptr];
  assign out_instr = fifo_instr[rd_ptr];

  // Control state: PCs, FIFO pointers/occupancy, request and drop bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      halted      <= 1'b0;
`endif
    end else if (redirect_valid) begin
      // A response landing this same cycle is itself one of the stale ones,
      // so it is subtracted rather than counted as still pending.
      fetch_pc    <= redir_target;
      rsp_pc      <= redir_target;
      rd_ptr      <= '0;
      outstanding <= outstanding - CW'(rsp_fire);
      drop_cnt    <= outstanding - CW'(rsp_fire);
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redir_mis) begin
        wr_ptr <= PW'(1);
        count  <= CW'(1);
        halted <= 1'b1;
      end else begin
        wr_ptr <= '0;
        count  <= '0;
        halted <= 1'b0;
      end
`else
      wr_ptr      <= '0;
      count       <= '0;
`endif
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        rsp_pc <= rsp_pc + XLEN'(4);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage: written by accepted responses, or by the misaligned marker.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= rsp_pc;
      fifo_instr[wr_ptr] <= imem_rsp_data;
`ifdef FETCH_MISALIGN_TRAP_EN
      fifo_mis[wr_ptr]   <= 1'b0;
`endif
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    if (redirect_valid && redir_mis) begin
      fifo_pc[0]    <= redirect_pc;
      fifo_instr[0] <= NOP;
      fifo_mis[0]   <= 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue with a fixed-latency
// in-order memory model. Stimulus pushes expected {pc, instr, misaligned}
// entries; a monitor pops and compares whenever decode consumes the head.
// Expectations for the FETCH_MISALIGN_TRAP_EN build are selected with the macro.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_misaligned;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] due;
  } mem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } exp_t;

  mem_t        mem_q[$];
  exp_t        exp_q[$];
  int          exp_cnt      = 0;
  int          n_checks     = 0;
  int          n_pass       = 0;
  int          cyc          = 0;
  int          mem_lat      = 1;
  int          fire_cnt     = 0;
  int          max_out_seen = 0;
  int          outs_now     = 0;
  logic        ready_en     = 1'b0;
  logic [31:0] special_addr = 32'hFFFF_FFFF;

  fetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_misaligned (out_misaligned)
  );

  always #5 clk = ~clk;

  // Decode only accepts while the scoreboard still expects something.
  assign out_ready = ready_en && (exp_cnt > 0);

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a == special_addr) ? 32'hDEADBEEF : {16'hC0DE, a[15:0]};
  endfunction

  // Memory response driver: returns each accepted request exactly mem_lat cycles later.
  always begin
    @(posedge clk);
    #2;
    cyc++;
    if (rst) begin
      mem_q.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end else if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  // Memory request capture plus bench-side count of requests in flight.
  always @(negedge clk) begin
    mem_t e;
    outs_now = mem_q.size() + (imem_rsp_valid ? 1 : 0);
    if (outs_now > max_out_seen) max_out_seen = outs_now;
    if (imem_req_valid && imem_req_ready) begin
      e.addr = imem_req_addr;
      e.due  = cyc + mem_lat;
      mem_q.push_back(e);
      fire_cnt++;
    end
  end

  // Scoreboard monitor: compare the FIFO head whenever decode consumes it.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready && !redirect_valid) begin
      e = exp_q.pop_front();
      exp_cnt--;
      n_checks++;
      if (out_pc === e.pc && out_instr === e.instr && out_misaligned === e.mis) begin
        n_pass++;
      end else begin
        $display("[TB] FAIL head: got pc=%h instr=%h mis=%b, want pc=%h instr=%h mis=%b",
                 out_pc, out_instr, out_misaligned, e.pc, e.instr, e.mis);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic redir, input logic [31:0] pc);
    @(posedge clk);
    #1;
    redirect_valid = redir;
    redirect_pc    = pc;
  endtask

  task automatic expectEntry(input logic [31:0] pc, input logic [31:0] instr, input logic mis);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    e.mis   = mis;
    exp_q.push_back(e);
    exp_cnt++;
  endtask

  task automatic expectSeq(input logic [31:0] start, input int n);
    logic [31:0] pc;
    for (int i = 0; i < n; i++) begin
      pc = start + 32'(4 * i);
      expectEntry(pc, {16'hC0DE, pc[15:0]}, 1'b0);
    end
  endtask

  task automatic flushExpected();
    exp_q.delete();
    exp_cnt = 0;
  endtask

  task automatic waitDrain(input string name, input int bound);
    for (int i = 0; i < bound && exp_cnt > 0; i++) @(negedge clk);
    checkOutput(name, 32'(exp_cnt), 32'd0);
  endtask

  task automatic applyReset(input int lat, input logic rdy_en);
    @(posedge clk);
    #1;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    ready_en       = 1'b0;
    special_addr   = 32'hFFFF_FFFF;
    mem_lat        = lat;
    flushExpected();
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_mis", 32'(out_misaligned), 32'd0);
    @(posedge clk);
    #1;
    fire_cnt     = 0;
    max_out_seen = 0;
    ready_en     = rdy_en;
    rst          = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;

    // Streaming: latency 1, always ready, one instruction per cycle from cycle 2.
    applyReset(1, 1'b1);
    expectSeq(32'h0, 10);
    @(negedge clk);
    checkOutput("c0_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("c0_req_addr", imem_req_addr, 32'h0);
    checkOutput("c0_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput("c1_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("stream_out_valid", 32'(out_valid), 32'd1);
    end
    waitDrain("drain_stream", 20);

    // Backpressure: decode stalled, exactly DEPTH requests fire, then drain in order.
    applyReset(1, 1'b0);
    repeat (12) @(negedge clk);
    checkOutput("bp_fire_cnt", 32'(fire_cnt), 32'd4);
    checkOutput("bp_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("bp_head_pc", out_pc, 32'h0);
    @(posedge clk);
    #1;
    ready_en = 1'b1;
    expectSeq(32'h0, 6);
    waitDrain("drain_bp", 30);

    // Latency 3: at most 2 outstanding, DEADBEEF reported at its own address.
    applyReset(3, 1'b1);
    special_addr = 32'h14;
    for (int i = 0; i < 8; i++) begin
      expectEntry(32'(4 * i), (i == 5) ? 32'hDEADBEEF : {16'hC0DE, 16'(4 * i)}, 1'b0);
    end
    waitDrain("drain_lat3", 80);
    checkOutput("lat3_max_outstanding", 32'(max_out_seen), 32'd2);

    // Back-to-back redirects (0x80 then 0x100) while 2 requests are in flight.
    applyReset(3, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (outs_now == 2 && out_valid) break;
    end
    checkOutput("redir_setup_outs", 32'(outs_now), 32'd2);
    applyStimulus(1'b1, 32'h80);
    @(negedge clk);
    checkOutput("redir1_req_valid", 32'(imem_req_valid), 32'd0);
    applyStimulus(1'b1, 32'h100);
    @(negedge clk);
    checkOutput("redir2_req_valid", 32'(imem_req_valid), 32'd0);
    applyStimulus(1'b0, 32'h0);
    expectSeq(32'h100, 2);
    @(negedge clk);
    checkOutput("redir_out_valid", 32'(out_valid), 32'd0);
    checkOutput("redir_req_addr", imem_req_addr, 32'h100);
    waitDrain("drain_redir", 30);

    // Redirect in the same cycle as a response and a consumable head.
    applyReset(1, 1'b1);
    expectSeq(32'h0, 3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (exp_cnt == 1) break;
    end
    checkOutput("coinc_setup_exp", 32'(exp_cnt), 32'd1);
    applyStimulus(1'b1, 32'h200);
    @(negedge clk);
    checkOutput("coinc_head_valid", 32'(out_valid), 32'd1);
    applyStimulus(1'b0, 32'h0);
    flushExpected();
    expectSeq(32'h200, 2);
    @(negedge clk);
    checkOutput("coinc_out_valid", 32'(out_valid), 32'd0);
    waitDrain("drain_coinc", 20);

    // Misaligned redirect target 0x102, then resume at 0x200.
    applyReset(1, 1'b0);
    repeat (8) @(negedge clk);
    applyStimulus(1'b1, 32'h102);
    applyStimulus(1'b0, 32'h0);
    fire_cnt = 0;
    ready_en = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
    expectEntry(32'h102, 32'h0000_0013, 1'b1);
    @(negedge clk);
    checkOutput("mis_req_valid", 32'(imem_req_valid), 32'd0);
    repeat (6) @(negedge clk);
    checkOutput("mis_fire_cnt", 32'(fire_cnt), 32'd0);
    waitDrain("drain_mis", 10);
`else
    expectSeq(32'h100, 3);
    @(negedge clk);
    checkOutput("mis_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("mis_req_addr", imem_req_addr, 32'h100);
    waitDrain("drain_mis", 20);
`endif
    applyStimulus(1'b1, 32'h200);
    applyStimulus(1'b0, 32'h0);
    flushExpected();
    expectSeq(32'h200, 2);
    waitDrain("drain_resume", 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
